// File: rtl/prbs_frame_ctrl.sv
// PRBS frame sequencer: reloads the LFSR, buffers one payload of PRBS bits and
// serialises preamble, payload and gap symbols for the ASK modulator.
module prbs_frame_ctrl #(
  parameter int PAYLOAD_LEN  = 32,
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_LEN      = 4,
  parameter int BIT_CYCLES   = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             repeat_en,
  input  logic             abort,
  input  logic             lfsr_bit,
  output logic             lfsr_load,
  output logic             busy,
  output logic             done,
  output logic             tx_en,
  output logic             tx_bit,
  output logic             sym_strobe,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int TMR_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int SYM_W = 8;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BIT_CYCLES - 1);
  localparam logic [SYM_W-1:0] FILL_LAST = SYM_W'(PAYLOAD_LEN - 1);
  localparam logic [SYM_W-1:0] PRE_LAST  = SYM_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
  localparam logic [SYM_W-1:0] GAP_LAST  = SYM_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, PREAMBLE, PAYLOAD, GAP} state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [SYM_W-1:0]       sym_q, sym_d;
  logic [PAYLOAD_LEN-1:0] pay_buf_q, pay_buf_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   lfsr_load_q, lfsr_load_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_en_q, tx_en_d;
  logic                   tx_bit_q, tx_bit_d;
  logic                   sym_strobe_q, sym_strobe_d;
  logic [SYM_W-1:0]       sym_last;
  logic                   pay_bit;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    sym_d       = sym_q;
    pay_buf_d   = pay_buf_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      PREAMBLE: sym_last = PRE_LAST;
      GAP:      sym_last = GAP_LAST;
      default:  sym_last = FILL_LAST;
    endcase

    case (state_q)
      IDLE: if (start && !abort) state_d = LOAD;
      LOAD: state_d = FILL;
      FILL: begin
        // Shift-in capture leaves the first PRBS bit at index 0 after the last capture
        pay_buf_d = pay_buf_q >> 1;
        pay_buf_d[PAYLOAD_LEN-1] = lfsr_bit;
        if (sym_q == FILL_LAST) state_d = (PREAMBLE_LEN > 0) ? PREAMBLE : PAYLOAD;
        else                    sym_d   = sym_q + SYM_W'(1);
      end
      PREAMBLE, PAYLOAD, GAP: begin
        if (tmr_q != TMR_LAST) begin
          tmr_d = tmr_q + TMR_W'(1);
        end else begin
          tmr_d = '0;
          if (sym_q != sym_last) begin
            sym_d = sym_q + SYM_W'(1);
          end else if (state_q == PREAMBLE) begin
            state_d = PAYLOAD;
          end else if (state_q == PAYLOAD && GAP_LEN > 0) begin
            state_d = GAP;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            done_d      = 1'b1;
            state_d     = repeat_en ? LOAD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end

    if (state_d != state_q) begin
      tmr_d = '0;
      sym_d = '0;
    end

    pay_bit = 1'b0;
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      if (sym_d == SYM_W'(i)) pay_bit = pay_buf_d[i];
    end

    lfsr_load_d  = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    tx_en_d      = (state_d == PREAMBLE) || (state_d == PAYLOAD);
    sym_strobe_d = ((state_d == PREAMBLE) || (state_d == PAYLOAD) || (state_d == GAP))
                   && (tmr_d == '0);
    case (state_d)
      PREAMBLE: tx_bit_d = ~sym_d[0];
      PAYLOAD:  tx_bit_d = pay_bit;
      default:  tx_bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      sym_q        <= '0;
      pay_buf_q    <= '0;
      frame_cnt_q  <= '0;
      lfsr_load_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_bit_q     <= 1'b0;
      sym_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      sym_q        <= sym_d;
      pay_buf_q    <= pay_buf_d;
      frame_cnt_q  <= frame_cnt_d;
      lfsr_load_q  <= lfsr_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_en_q      <= tx_en_d;
      tx_bit_q     <= tx_bit_d;
      sym_strobe_q <= sym_strobe_d;
    end
  end

  assign lfsr_load  = lfsr_load_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_en      = tx_en_q;
  assign tx_bit     = tx_bit_q;
  assign sym_strobe = sym_strobe_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Scoreboard bench for prbs_frame_ctrl: a default-size instance checked through
// symbol/done queues, and a minimal instance checked cycle by cycle.
module tb_prbs_frame_ctrl;

  localparam int PL    = 32;
  localparam int PRE   = 8;
  localparam int GAP   = 4;
  localparam int BC    = 16;
  localparam int FRAME = 1 + PL + (PRE + PL + GAP) * BC;
  localparam logic [12:0] SEED = 13'h0001;

  typedef struct packed { logic en; logic val; } sym_t;
  typedef struct { int cyc; int cnt; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start_a = 1'b0, repeat_a = 1'b0, abort_a = 1'b0, lfsr_bit_a;
  logic load_a, busy_a, done_a, tx_en_a, tx_bit_a, strobe_a;
  logic [7:0] cnt_a;

  logic start_b = 1'b0, repeat_b = 1'b0, abort_b = 1'b0, lfsr_bit_b;
  logic load_b, busy_b, done_b, tx_en_b, tx_bit_b, strobe_b;
  logic [1:0] cnt_b;

  logic [12:0] lfsr_a = SEED;
  logic [12:0] lfsr_b = SEED;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    cnt_model = 0;
  sym_t  sym_q[$];
  done_t done_q[$];
  sym_t  cur = '0;
  sym_t  exp_s;
  done_t exp_d;
  logic  exp_payload [PL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External 13-bit LFSR (x^13+x^4+x^3+x+1), outbit taken from state bit 7
  function automatic logic [12:0] lfsrNext(input logic [12:0] s);
    return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
  endfunction

  always @(posedge clk) lfsr_a <= load_a ? SEED : lfsrNext(lfsr_a);
  always @(posedge clk) lfsr_b <= load_b ? SEED : lfsrNext(lfsr_b);
  assign lfsr_bit_a = lfsr_a[7];
  assign lfsr_bit_b = lfsr_b[7];

  prbs_frame_ctrl #(
    .PAYLOAD_LEN(PL), .PREAMBLE_LEN(PRE), .GAP_LEN(GAP), .BIT_CYCLES(BC), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .repeat_en(repeat_a), .abort(abort_a),
    .lfsr_bit(lfsr_bit_a), .lfsr_load(load_a), .busy(busy_a), .done(done_a),
    .tx_en(tx_en_a), .tx_bit(tx_bit_a), .sym_strobe(strobe_a), .frame_cnt(cnt_a)
  );

  prbs_frame_ctrl #(
    .PAYLOAD_LEN(1), .PREAMBLE_LEN(0), .GAP_LEN(0), .BIT_CYCLES(1), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .repeat_en(repeat_b), .abort(abort_b),
    .lfsr_bit(lfsr_bit_b), .lfsr_load(load_b), .busy(busy_b), .done(done_b),
    .tx_en(tx_en_b), .tx_bit(tx_bit_b), .sym_strobe(strobe_b), .frame_cnt(cnt_b)
  );

  // Monitor: pops expected symbols on each strobe, checks the symbol is held
  // between strobes, and pops expected completion cycle/count on each done
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_a || !busy_a) cur = '0;
      if (strobe_a) begin
        checks++;
        if (sym_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_symbol: got en=%0b bit=%0b at cycle %0d, expected no symbol",
                   tx_en_a, tx_bit_a, cyc);
        end else begin
          exp_s = sym_q.pop_front();
          cur = exp_s;
          if ({tx_en_a, tx_bit_a} !== exp_s) begin
            errors++;
            $display("[TB] FAIL symbol_value: got en=%0b bit=%0b, expected en=%0b bit=%0b at cycle %0d",
                     tx_en_a, tx_bit_a, exp_s.en, exp_s.val, cyc);
          end
        end
      end else if (busy_a) begin
        checks++;
        if ({tx_en_a, tx_bit_a} !== cur) begin
          errors++;
          $display("[TB] FAIL symbol_hold: got en=%0b bit=%0b, expected en=%0b bit=%0b at cycle %0d",
                   tx_en_a, tx_bit_a, cur.en, cur.val, cyc);
        end
      end
      if (done_a) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          exp_d = done_q.pop_front();
          if (cyc != exp_d.cyc || cnt_a !== 8'(exp_d.cnt)) begin
            errors++;
            $display("[TB] FAIL done_event: got cycle %0d cnt %0d, expected cycle %0d cnt %0d",
                     cyc, cnt_a, exp_d.cyc, exp_d.cnt);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushSymbols(input int n);
    for (int i = 0; i < PRE + PL + GAP && i < n; i++) begin
      sym_t s;
      if (i < PRE)           s = {1'b1, (i % 2 == 0)};
      else if (i < PRE + PL) s = {1'b1, exp_payload[i-PRE]};
      else                   s = 2'b00;
      sym_q.push_back(s);
    end
  endtask

  task automatic pushDone(input int at);
    done_t d;
    cnt_model = (cnt_model + 1) % 256;
    d.cyc = at;
    d.cnt = cnt_model;
    done_q.push_back(d);
  endtask

  // Called at a negedge; e0 is the cyc value after the edge that samples start
  task automatic applyStimulus(input bit full, output int e0);
    e0 = cyc + 1;
    if (full) begin
      pushSymbols(PRE + PL + GAP);
      pushDone(e0 + FRAME);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic waitFrames(input int budget);
    int n = 0;
    while ((sym_q.size() != 0 || done_q.size() != 0 || busy_a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sym_q.size() != 0 || done_q.size() != 0 || busy_a) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_timeout: got %0d symbols %0d dones pending, expected 0 within %0d cycles",
               sym_q.size(), done_q.size(), budget);
    end
  endtask

  initial begin
    int e0;
    int drops;
    logic [12:0] s;

    s = SEED;
    for (int k = 0; k < PL; k++) begin
      exp_payload[k] = s[7];
      s = lfsrNext(s);
    end

    @(negedge clk);
    checkOutput("reset_outputs_a", {load_a, busy_a, done_a, tx_en_a, tx_bit_a, strobe_a, cnt_a}, 0);
    checkOutput("reset_outputs_b", {load_b, busy_b, done_b, tx_en_b, tx_bit_b, strobe_b, cnt_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single frame");
    applyStimulus(1, e0);
    checkOutput("lfsr_load_first", {load_a, busy_a}, 2'b11);
    @(negedge clk);
    checkOutput("lfsr_load_single", load_a, 0);
    waitCyc(e0 + 32);
    checkOutput("no_strobe_in_fill", {strobe_a, tx_en_a}, 0);
    waitCyc(e0 + 33);
    checkOutput("first_preamble_strobe", {strobe_a, tx_en_a, tx_bit_a}, 3'b111);
    waitFrames(FRAME + 20);
    checkOutput("busy_after_frame", busy_a, 0);
    checkOutput("cnt_single", cnt_a, 1);

    $display("[TB] repeat mode");
    repeat_a = 1'b1;
    applyStimulus(0, e0);
    for (int f = 1; f <= 3; f++) begin
      pushSymbols(PRE + PL + GAP);
      pushDone(e0 + f * FRAME);
    end
    drops = 0;
    while (cyc < e0 + 3 * FRAME) begin
      if (cyc == e0 + 2 * FRAME + 5) repeat_a = 1'b0;
      if (!busy_a) drops++;
      @(negedge clk);
    end
    checkOutput("repeat_busy_continuous", drops, 0);
    waitFrames(100);
    checkOutput("cnt_after_repeat", cnt_a, 4);

    $display("[TB] abort in payload symbol 5");
    applyStimulus(0, e0);
    pushSymbols(PRE + 6);
    waitCyc(e0 + 243);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checkOutput("abort_outputs", {busy_a, tx_en_a, tx_bit_a, strobe_a, done_a}, 0);
    checkOutput("abort_cnt", cnt_a, cnt_model);
    repeat (20) @(negedge clk);
    checkOutput("abort_symbols_consumed", sym_q.size(), 0);
    applyStimulus(1, e0);
    waitFrames(FRAME + 20);
    checkOutput("cnt_after_abort_restart", cnt_a, 5);

    $display("[TB] start while busy");
    applyStimulus(1, e0);
    waitCyc(e0 + 100);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitCyc(e0 + 500);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    waitFrames(FRAME + 20);
    repeat (30) @(negedge clk);
    checkOutput("busy_ignores_start", busy_a, 0);
    checkOutput("cnt_start_busy", cnt_a, 6);

    $display("[TB] minimal frame and 2-bit counter wrap");
    for (int f = 0; f < 5; f++) begin
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      checkOutput("b_load", {load_b, busy_b, tx_en_b, tx_bit_b, strobe_b, done_b}, 6'b110000);
      @(negedge clk);
      checkOutput("b_fill", {load_b, busy_b, tx_en_b, tx_bit_b, strobe_b, done_b}, 6'b010000);
      @(negedge clk);
      checkOutput("b_payload", {load_b, busy_b, tx_en_b, tx_bit_b, strobe_b, done_b},
                  {3'b011, exp_payload[0], 2'b10});
      @(negedge clk);
      checkOutput("b_done", {load_b, busy_b, tx_en_b, tx_bit_b, strobe_b, done_b}, 6'b000001);
      checkOutput("b_frame_cnt", cnt_b, (f + 1) % 4);
    end

    $display("[TB] asynchronous reset mid-fill");
    applyStimulus(0, e0);
    waitCyc(e0 + 10);
    checkOutput("busy_before_reset", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_a", {load_a, busy_a, done_a, tx_en_a, tx_bit_a, strobe_a, cnt_a}, 0);
    checkOutput("async_reset_b_cnt", cnt_b, 0);
    cnt_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, e0);
    waitFrames(FRAME + 20);
    checkOutput("cnt_after_reset_frame", cnt_a, 1);
    checkOutput("sb_symbols_left", sym_q.size(), 0);
    checkOutput("sb_done_left", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
